// File: rtl/hazard_ctrl.sv
// hazard_ctrl: EX operand forwarding selects, load-use stall and taken-branch flush from a
// registered EX/MEM/WB destination shadow. Optional event counters under HAZ_PERF_CNT_EN.
module hazard_ctrl #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] d_rs1,
   input  logic [REG_AW-1:0] d_rs2,
   input  logic              d_use_rs1,
   input  logic              d_use_rs2,
   input  logic [REG_AW-1:0] d_rd,
   input  logic              d_reg_write,
   input  logic              d_is_load,
   input  logic              ex_br_taken,
   input  logic              ext_stall,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic              stall_f,
   output logic              stall_d,
   output logic              flush_d,
   output logic              flush_e,
   output logic              freeze
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  lu_stall_cnt,
   output logic [CNT_W-1:0]  br_flush_cnt
`endif
);

   typedef struct packed {
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic              we;
      logic              ld;
   } ex_ent_t;

   // The load flag only matters while the load sits in EX, so MEM/WB keep just rd/we.
   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic              we;
   } wr_ent_t;

   ex_ent_t ex_q, ex_d;
   wr_ent_t mem_q, mem_d;
   wr_ent_t wb_q, wb_d;

   logic rs1_hit;
   logic rs2_hit;
   logic lu;

   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                          input wr_ent_t           mem,
                                          input wr_ent_t           wb);
      logic [1:0] sel;
      sel = 2'b00;
      if (mem.we && (mem.rd != '0) && (mem.rd == src))
         sel = 2'b10;
      else if (wb.we && (wb.rd != '0) && (wb.rd == src))
         sel = 2'b01;
      return sel;
   endfunction

   assign rs1_hit = d_use_rs1 && (d_rs1 == ex_q.rd);
   assign rs2_hit = d_use_rs2 && (d_rs2 == ex_q.rd);
   assign lu      = ex_q.ld && ex_q.we && (ex_q.rd != '0) && (rs1_hit || rs2_hit);

   always_comb begin
      stall_f   = 1'b0;
      stall_d   = 1'b0;
      flush_d   = 1'b0;
      flush_e   = 1'b0;
      freeze    = ext_stall;
      fwd_a_sel = fwd_sel(ex_q.rs1, mem_q, wb_q);
      fwd_b_sel = fwd_sel(ex_q.rs2, mem_q, wb_q);
      if (rst_n) begin
         if (ext_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
         end else if (ex_br_taken) begin
            // Branch beats load-use: the stalled Decode instruction is on the wrong path.
            flush_d = 1'b1;
            flush_e = 1'b1;
         end else if (lu) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
         end
      end
   end

   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (!ext_stall) begin
         wb_d  = mem_q;
         mem_d = '{rd: ex_q.rd, we: ex_q.we};
         if (flush_e)
            ex_d = '0;
         else
            ex_d = '{rs1: d_rs1, rs2: d_rs2, rd: d_rd, we: d_reg_write, ld: d_is_load};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;

   always_comb begin
      lu_cnt_d = lu_cnt_q;
      br_cnt_d = br_cnt_q;
      if (!ext_stall) begin
         if (ex_br_taken)
            br_cnt_d = br_cnt_q + CNT_W'(1);
         else if (lu)
            lu_cnt_d = lu_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lu_cnt_q <= '0;
         br_cnt_q <= '0;
      end else begin
         lu_cnt_q <= lu_cnt_d;
         br_cnt_q <= br_cnt_d;
      end
   end

   assign lu_stall_cnt = lu_cnt_q;
   assign br_flush_cnt = br_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed hazard scenarios followed by random traffic, checked against a queue-based pipeline model.
module tb_hazard_ctrl;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] d_rs1, d_rs2, d_rd;
   logic          d_use_rs1, d_use_rs2, d_reg_write, d_is_load, ex_br_taken, ext_stall;
   logic [1:0]    fwd_a_sel, fwd_b_sel;
   logic          stall_f, stall_d, flush_d, flush_e, freeze;
`ifdef HAZ_PERF_CNT_EN
   logic [31:0]   lu_stall_cnt, br_flush_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int rs1;
      int rs2;
      int rd;
      bit we;
      bit ld;
   } ent_t;

   ent_t        pipe[$];   // [0]=EX [1]=MEM [2]=WB
   logic [31:0] m_lu_cnt, m_br_cnt;
   logic [1:0]  e_fa, e_fb;
   logic        e_sf, e_sd, e_fd, e_fe, e_fz;

   hazard_ctrl #(.REG_AW(AW), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
      .d_rd(d_rd), .d_reg_write(d_reg_write), .d_is_load(d_is_load),
      .ex_br_taken(ex_br_taken), .ext_stall(ext_stall),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
      .freeze(freeze)
`ifdef HAZ_PERF_CNT_EN
      , .lu_stall_cnt(lu_stall_cnt), .br_flush_cnt(br_flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic ent_t bubble();
      ent_t b;
      b = '{rs1: 0, rs2: 0, rd: 0, we: 1'b0, ld: 1'b0};
      return b;
   endfunction

   function automatic logic [1:0] m_fwd(input int src);
      if (pipe[1].we && pipe[1].rd != 0 && pipe[1].rd == src) return 2'b10;
      if (pipe[2].we && pipe[2].rd != 0 && pipe[2].rd == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit m_lu();
      ent_t e;
      e = pipe[0];
      return e.ld && e.we && e.rd != 0 &&
             ((d_use_rs1 && int'(d_rs1) == e.rd) || (d_use_rs2 && int'(d_rs2) == e.rd));
   endfunction

   task automatic m_reset();
      pipe = {};
      repeat (3) pipe.push_back(bubble());
      m_lu_cnt = '0;
      m_br_cnt = '0;
   endtask

   // Instruction flow: every unfrozen edge a new instruction (or bubble) enters EX, WB retires.
   always @(posedge clk) begin
      if (rst_n && !ext_stall) begin
         ent_t n;
         bit   kill;
         kill = ex_br_taken || m_lu();
         if (ex_br_taken) m_br_cnt = m_br_cnt + 1;
         else if (m_lu()) m_lu_cnt = m_lu_cnt + 1;
         n = kill ? bubble() : '{rs1: int'(d_rs1), rs2: int'(d_rs2), rd: int'(d_rd),
                                 we: d_reg_write, ld: d_is_load};
         pipe.push_front(n);
         void'(pipe.pop_back());
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      e_fa = m_fwd(pipe[0].rs1);
      e_fb = m_fwd(pipe[0].rs2);
      {e_sf, e_sd, e_fd, e_fe} = 4'b0000;
      e_fz = ext_stall;
      if (rst_n) begin
         if (ext_stall)        {e_sf, e_sd} = 2'b11;
         else if (ex_br_taken) {e_fd, e_fe} = 2'b11;
         else if (m_lu())      {e_sf, e_sd, e_fe} = 3'b111;
      end
      chk({tag, ".fwd_a"},   64'(fwd_a_sel), 64'(e_fa));
      chk({tag, ".fwd_b"},   64'(fwd_b_sel), 64'(e_fb));
      chk({tag, ".stall_f"}, 64'(stall_f),   64'(e_sf));
      chk({tag, ".stall_d"}, 64'(stall_d),   64'(e_sd));
      chk({tag, ".flush_d"}, 64'(flush_d),   64'(e_fd));
      chk({tag, ".flush_e"}, 64'(flush_e),   64'(e_fe));
      chk({tag, ".freeze"},  64'(freeze),    64'(e_fz));
`ifdef HAZ_PERF_CNT_EN
      chk({tag, ".lu_cnt"},  64'(lu_stall_cnt), 64'(m_lu_cnt));
      chk({tag, ".br_cnt"},  64'(br_flush_cnt), 64'(m_br_cnt));
`endif
   endtask

   task automatic drv(input int rs1, input int rs2, input bit u1, input bit u2, input int rd,
                      input bit we, input bit ld, input bit br, input bit st, input string tag);
      @(negedge clk);
      d_rs1 = rs1[AW-1:0];  d_rs2 = rs2[AW-1:0];
      d_use_rs1 = u1;       d_use_rs2 = u2;
      d_rd = rd[AW-1:0];    d_reg_write = we;  d_is_load = ld;
      ex_br_taken = br;     ext_stall = st;
      #1;
      check_all(tag);
   endtask

   initial begin
      rst_n = 1'b0;
      d_rs1 = '0; d_rs2 = '0; d_rd = '0;
      d_use_rs1 = 1'b0; d_use_rs2 = 1'b0; d_reg_write = 1'b0; d_is_load = 1'b0;
      ex_br_taken = 1'b1; ext_stall = 1'b0;
      m_reset();
      #2;
      check_all("rst");
      ext_stall = 1'b1;
      #1;
      check_all("rst_frz");
      chk("rst_frz.freeze_lit", 64'(freeze), 64'd1);
      ext_stall = 1'b0; ex_br_taken = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // MEM forwarding
      drv(1, 2, 1, 1, 5, 1, 0, 0, 0, "t1_add");
      drv(5, 3, 1, 1, 6, 1, 0, 0, 0, "t1_use");
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, "t1_chk");
      chk("t1.fwd_a_lit", 64'(fwd_a_sel), 64'd2);
      chk("t1.fwd_b_lit", 64'(fwd_b_sel), 64'd0);

      // WB only, MEM+WB priority, x0
      drv(1, 2, 1, 1, 5, 1, 0, 0, 0, "t2_add");
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, "t2_nop");
      drv(5, 5, 1, 1, 6, 1, 0, 0, 0, "t2_use");
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, "t2_wb");
      chk("t2.wb_lit", 64'({fwd_a_sel, fwd_b_sel}), 64'b0101);
      drv(1, 2, 1, 1, 5, 1, 0, 0, 0, "t2_add1");
      drv(3, 4, 1, 1, 5, 1, 0, 0, 0, "t2_add2");
      drv(5, 9, 1, 1, 6, 1, 0, 0, 0, "t2_use2");
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, "t2_both");
      chk("t2.both_lit", 64'(fwd_a_sel), 64'd2);
      drv(1, 2, 1, 1, 0, 1, 0, 0, 0, "t2_x0w");
      drv(0, 0, 1, 1, 6, 1, 0, 0, 0, "t2_x0u");
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, "t2_x0");
      chk("t2.x0_lit", 64'({fwd_a_sel, fwd_b_sel}), 64'b0000);

      // Load-use
      drv(1, 0, 1, 0, 7, 1, 1, 0, 0, "t3_lw");
      drv(2, 7, 1, 1, 8, 1, 0, 0, 0, "t3_lu");
      chk("t3.lu_lit", 64'({stall_f, stall_d, flush_d, flush_e}), 64'b1101);
      drv(2, 7, 1, 1, 8, 1, 0, 0, 0, "t3_hold");
      chk("t3.one_cycle_lit", 64'({stall_f, stall_d, flush_e}), 64'b000);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, "t3_fwd");
      chk("t3.fwd_b_lit", 64'(fwd_b_sel), 64'd1);

      // Branch beats load-use
      drv(1, 0, 1, 0, 7, 1, 1, 0, 0, "t4_lw");
      drv(2, 7, 1, 1, 8, 1, 0, 1, 0, "t4_br");
      chk("t4.br_lit", 64'({stall_f, stall_d, flush_d, flush_e}), 64'b0011);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, "t4_after");

      // Freeze holds branch and selects
      drv(1, 2, 1, 1, 5, 1, 0, 0, 0, "t5_add");
      drv(5, 0, 1, 0, 6, 1, 0, 0, 0, "t5_use");
      for (int i = 0; i < 3; i++) begin
         drv(0, 0, 0, 0, 0, 0, 0, 1, 1, "t5_frz");
         chk("t5.frz_lit", 64'({fwd_a_sel, flush_d, flush_e, stall_f, freeze}), 64'b100011);
      end
      drv(0, 0, 0, 0, 0, 0, 0, 1, 0, "t5_rel");
      chk("t5.rel_lit", 64'({flush_d, flush_e, stall_f}), 64'b110);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, "t5_post");

      // Asynchronous reset while a MEM match is live
      drv(1, 2, 1, 1, 5, 1, 0, 0, 0, "t6_add");
      drv(5, 0, 1, 0, 6, 1, 0, 0, 0, "t6_use");
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, "t6_pre");
      chk("t6.pre_lit", 64'(fwd_a_sel), 64'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6.rst_fwd_lit", 64'({fwd_a_sel, fwd_b_sel}), 64'b0000);
      m_reset();
      check_all("t6_rst");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 400; i++) begin
         drv(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), bit'($urandom_range(0, 3) != 0),
             bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 7) == 0),
             bit'($urandom_range(0, 7) == 0), "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
